// File: rtl/memory_weights_loader.sv
// Packs LANES consecutive input beats into one DATA_WIDTH row and writes rows
// 0..N-1 of a weight memory, one single-cycle write per completed row.
module memory_weights_loader #(
    parameter int DATA_WIDTH = 1024,
    parameter int ADDR_DEPTH = 1024,
    parameter int ADDR_WIDTH = $clog2(ADDR_DEPTH),
    parameter int IN_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_rows,
    input  logic                  s_valid,
    input  logic [IN_WIDTH-1:0]   s_data,
    output logic                  s_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done
);
    localparam int LANES  = DATA_WIDTH / IN_WIDTH;
    localparam int LANE_W = $clog2(LANES);
    localparam logic [ADDR_WIDTH:0] MAX_ROWS = (ADDR_WIDTH+1)'(ADDR_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    // Handshake: a beat moves only on a cycle with s_valid & s_ready both high;
    // s_ready depends on state alone, never on s_valid.
    logic [1:0]                       state;
    logic [ADDR_WIDTH:0]              n_rows;
    logic [ADDR_WIDTH-1:0]            row_cnt;
    logic [LANE_W-1:0]                lane_cnt;
    logic [LANES-1:0][IN_WIDTH-1:0]   acc;
    logic [LANES-1:0][IN_WIDTH-1:0]   acc_next;
    logic [ADDR_WIDTH:0]              n_clamped;
    logic                             lane_last;
    logic                             row_last;

    assign n_clamped = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
    assign lane_last = (lane_cnt == LANE_W'(LANES - 1));
    assign row_last  = ({1'b0, row_cnt} == (n_rows - (ADDR_WIDTH+1)'(1)));

    // Row with the incoming beat merged, so the final lane reaches wdata directly.
    always_comb begin
        acc_next           = acc;
        acc_next[lane_cnt] = s_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            n_rows   <= '0;
            row_cnt  <= '0;
            lane_cnt <= '0;
            acc      <= '0;
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
        end else begin
            we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_rows   <= n_clamped;
                        row_cnt  <= '0;
                        lane_cnt <= '0;
                        acc      <= '0;
                        state    <= (n_clamped == '0) ? S_FIN : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (s_valid) begin
                        acc <= acc_next;
                        if (lane_last) begin
                            lane_cnt <= '0;
                            we       <= 1'b1;
                            waddr    <= row_cnt;
                            wdata    <= acc_next;
                            if (row_last) begin
                                state <= S_FLUSH;
                            end else begin
                                row_cnt <= row_cnt + ADDR_WIDTH'(1);
                            end
                        end else begin
                            lane_cnt <= lane_cnt + LANE_W'(1);
                        end
                    end
                end
                S_FLUSH: state <= S_FIN;
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign s_ready = (state == S_LOAD);
    assign busy    = (state == S_LOAD) || (state == S_FLUSH);
    assign done    = (state == S_FIN);
endmodule

// File: doc/memory_weights_loader.md
# memory_weights_loader

Write-side companion of the weight ROM. Accepts a narrow valid/ready stream of weight words, packs `LANES = DATA_WIDTH/IN_WIDTH` consecutive beats into one `DATA_WIDTH`-bit row, and issues one single-cycle write per row to a weight memory's write port. Sits between the host/DMA input stream and the weight RAM, and fills rows `0 .. N-1` per `start` command.

## Interface
- `DATA_WIDTH`, 1024: memory row width in bits.
- `ADDR_DEPTH`, 1024: number of memory rows.
- `ADDR_WIDTH`, `$clog2(ADDR_DEPTH)`: row address width.
- `IN_WIDTH`, 32: input beat width. `DATA_WIDTH % IN_WIDTH == 0` is required; `LANES = DATA_WIDTH/IN_WIDTH` and must be at least 2.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle load command; sampled only in IDLE.
- `num_rows` in `ADDR_WIDTH+1`: rows to load; sampled with `start`.
- `s_valid` in 1: input beat valid.
- `s_data` in `IN_WIDTH`: input beat.
- `s_ready` out 1: beat accepted when `s_valid & s_ready`.
- `we` out 1: memory write enable, one-cycle pulse per row.
- `waddr` out `ADDR_WIDTH`: row address qualified by `we`.
- `wdata` out `DATA_WIDTH`: row data qualified by `we`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the load completes.

## Operation
- States are IDLE, LOAD, FLUSH and FIN.
- IDLE:
  - `start=1` latches `min(num_rows, ADDR_DEPTH)` as N and clears the lane counter, row counter and accumulator.
  - If N>0, go to LOAD; if N==0, go to FIN.
- LOAD:
  - `s_ready=1`.
  - Each handshake places `s_data` in lane `lane_cnt`, i.e. bits `[lane_cnt*IN_WIDTH +: IN_WIDTH]`. Lane 0 is the LSBs, and the first beat goes to lane 0.
  - A handshake on lane `LANES-1` completes the row. On the next cycle `we=1`, `waddr=row_cnt`, and `wdata` is the full row including the final beat.
  - After a completed row, `lane_cnt` returns to 0 and `row_cnt` increments.
  - If the completed row was row N-1, go to FLUSH (`s_ready` drops the cycle after that beat). Otherwise stay in LOAD. Back-to-back rows are allowed at 1 beat per cycle.
- FLUSH: the final `we` is on the outputs; go to FIN.
- FIN: `done=1` for one cycle, `busy=0`; go to IDLE.
- `s_ready` is driven from state only (LOAD). It does not depend on `s_valid`.
- Beats presented outside LOAD are not consumed.
- `start` outside IDLE is ignored.
- `wdata` and `waddr` hold their last written values while `we=0`.

## Timing
- Reset values: `s_ready=0`, `we=0`, `waddr=0`, `wdata=0`, `busy=0`, `done=0`. State is IDLE and all counters are 0.
- `start` accepted in cycle T:
  - `busy=1` and `s_ready=1` (N>0) from T+1.
  - For N==0: `done=1` at T+1, and `busy` stays 0.
- Write latency: `we` is asserted 1 cycle after the last-lane handshake of a row.
- Completion: with the last beat of row N-1 accepted at cycle L, `we`/`waddr=N-1` at L+1, `done=1` at L+2, and `busy=0` from L+2.
- Minimum row-to-row write spacing is `LANES` cycles. Stalls (`s_valid=0`) only delay the sequence; data and addresses are unchanged.
- `rst` mid-load:
  - The next cycle is IDLE with reset outputs.
  - Any partial row is discarded, and no `we` is issued for it. This includes a `we` that would have followed a final beat accepted in the same cycle as `rst`.
  - The next load starts at row 0, lane 0.
- `row_cnt` never exceeds N-1, so `waddr` never wraps past `ADDR_DEPTH-1`.

## Test plan
Bench configuration: `IN_WIDTH=32`, `DATA_WIDTH=128` (LANES=4), `ADDR_DEPTH=8`.
- Reset: hold `rst` for 3 cycles with `s_valid=1` -> all outputs 0, `s_ready=0`, no `we`.
- Basic load:
  - Stimulus: `start` with `num_rows=2`, then 8 continuous beats 0x0..0x7.
  - `we` at the cycles after beats 4 and 8.
  - Row 0: `waddr=0`, `wdata=0x00000003_00000002_00000001_00000000`.
  - Row 1: `waddr=1`, `wdata=0x00000007_00000006_00000005_00000004`.
  - `done` 2 cycles after beat 8; `busy` low with `done`.
- Backpressure: same load with `s_valid` randomly deasserted (about 50%) -> identical `we`/`waddr`/`wdata` sequence, exactly 2 `we` pulses.
- Boundaries:
  - `num_rows=0` -> `done` the cycle after `start`, no `we`, `s_ready` stays 0.
  - `num_rows=9` -> clamped to 8; 8 writes to `waddr` 0..7, none beyond.
- Reset mid-row: `num_rows=2`, 6 beats, then `rst` -> no second `we`. Then `start` with `num_rows=1` and beats 0xA..0xD -> one write, `waddr=0`, `wdata=0x0000000D_0000000C_0000000B_0000000A`.
- Ignored start: pulse `start` with `num_rows=5` during an N=1 load -> exactly 1 `we` and 1 `done`; 5 extra beats offered afterward are not consumed.
